vscale_htif_pcr_responder: RTL and testbench

Target-side responder for the HTIF PCR request/response interface. It accepts host read/write requests on the tohost/fromhost registers and returns one response per request through a one-entry response buffer. It exposes a simple register port to the core pipeline and sits between the host/testbench HTIF port and the core CSR logic in `vscale_sim_top`.

---
 rtl/vscale_htif_pcr_responder.sv | 109 ++++++++++
 tb/tb_vscale_htif_pcr_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_htif_pcr_responder.sv
// HTIF PCR target responder: host access to tohost/fromhost with a one-entry registered response buffer.
// Optional build macro VSCALE_HTIF_TOHOST_CLEAR_ON_READ_EN makes host reads of tohost clear it.
module vscale_htif_pcr_responder #(
    parameter int          PCR_WIDTH      = 64,
    parameter logic [11:0] ADDR_TO_HOST   = 12'h780,
    parameter logic [11:0] ADDR_FROM_HOST = 12'h781
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 htif_pcr_req_valid,
    output logic                 htif_pcr_req_ready,
    input  logic                 htif_pcr_req_rw,
    input  logic [11:0]          htif_pcr_req_addr,
    input  logic [PCR_WIDTH-1:0] htif_pcr_req_data,
    output logic                 htif_pcr_resp_valid,
    input  logic                 htif_pcr_resp_ready,
    output logic [PCR_WIDTH-1:0] htif_pcr_resp_data,
    input  logic                 core_tohost_wen,
    input  logic [31:0]          core_tohost_wdata,
    input  logic                 core_fromhost_clr,
    output logic [31:0]          core_fromhost_rdata,
    output logic                 tohost_pending
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state;
    logic [PCR_WIDTH-1:0] tohost;
    logic [PCR_WIDTH-1:0] fromhost;
    logic [PCR_WIDTH-1:0] rdata;
    logic [PCR_WIDTH-1:0] read_data;
    logic                 accept;
    logic                 host_write_fromhost;
    logic                 tohost_rd_clr;

    // A full buffer can still take a request in the cycle the host drains it.
    assign htif_pcr_req_ready  = (state == IDLE) || htif_pcr_resp_ready;
    assign accept              = htif_pcr_req_valid && htif_pcr_req_ready;
    assign host_write_fromhost = accept && htif_pcr_req_rw && (htif_pcr_req_addr == ADDR_FROM_HOST);

`ifdef VSCALE_HTIF_TOHOST_CLEAR_ON_READ_EN
    assign tohost_rd_clr = accept && !htif_pcr_req_rw && (htif_pcr_req_addr == ADDR_TO_HOST);
`else
    assign tohost_rd_clr = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise unmatched paths infer a latch.
        read_data = '0;
        if (!htif_pcr_req_rw) begin
            if (htif_pcr_req_addr == ADDR_TO_HOST)
                read_data = tohost;
            else if (htif_pcr_req_addr == ADDR_FROM_HOST)
                read_data = fromhost;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RESP;
                        rdata <= read_data;
                    end
                end
                RESP: begin
                    if (htif_pcr_resp_ready) begin
                        if (accept)
                            rdata <= read_data;
                        else
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Core write has priority over the optional read-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tohost <= '0;
        else if (core_tohost_wen)
            tohost <= PCR_WIDTH'(core_tohost_wdata);
        else if (tohost_rd_clr)
            tohost <= '0;
    end

    // Host write has priority over the core clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fromhost <= '0;
        else if (host_write_fromhost)
            fromhost <= htif_pcr_req_data;
        else if (core_fromhost_clr)
            fromhost <= '0;
    end

    assign htif_pcr_resp_valid = (state == RESP);
    assign htif_pcr_resp_data  = rdata;
    assign core_fromhost_rdata = fromhost[31:0];
    assign tohost_pending      = |tohost;

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Self-checking bench for vscale_htif_pcr_responder: reference model plus response scoreboard.
// Expectations follow the VSCALE_HTIF_TOHOST_CLEAR_ON_READ_EN build setting.
module tb_vscale_htif_pcr_responder;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_rw = 1'b0;
    logic [11:0]  req_addr = '0;
    logic [W-1:0] req_data = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_data;
    logic         core_tohost_wen = 1'b0;
    logic [31:0]  core_tohost_wdata = '0;
    logic         core_fromhost_clr = 1'b0;
    logic [31:0]  core_fromhost_rdata;
    logic         tohost_pending;

    always #5 clk = ~clk;

    vscale_htif_pcr_responder #(.PCR_WIDTH(W)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .core_tohost_wen     (core_tohost_wen),
        .core_tohost_wdata   (core_tohost_wdata),
        .core_fromhost_clr   (core_fromhost_clr),
        .core_fromhost_rdata (core_fromhost_rdata),
        .tohost_pending      (tohost_pending)
    );

`ifdef VSCALE_HTIF_TOHOST_CLEAR_ON_READ_EN
    localparam bit CLR_ON_READ = 1'b1;
`else
    localparam bit CLR_ON_READ = 1'b0;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_resp  = 0;
    int           cnt_2a  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_tohost   = '0;
    logic [W-1:0] m_fromhost = '0;
    logic         m_valid    = 1'b0;
    logic [W-1:0] held;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, score responses, then advance the model past the edge.
    task automatic step();
        logic         acc;
        logic [W-1:0] e;
        @(negedge clk);
        check("req_ready", W'(req_ready), W'(!m_valid || resp_ready));
        check("resp_valid", W'(resp_valid), W'(m_valid));
        check("tohost_pending", W'(tohost_pending), W'(m_tohost != '0));
        check("core_fromhost_rdata", W'(core_fromhost_rdata), W'(m_fromhost[31:0]));
        if (resp_valid && resp_ready) begin
            n_resp++;
            if (resp_data == W'(32'h2A)) cnt_2a++;
            if (exp_q.size() == 0) begin
                check("resp_spurious", W'(resp_valid), W'(1'b0));
            end else begin
                e = exp_q.pop_front();
                check("resp_data", resp_data, e);
            end
        end
        acc = req_valid && (!m_valid || resp_ready);
        if (acc) begin
            e = '0;
            if (!req_rw && req_addr == 12'h780) e = m_tohost;
            if (!req_rw && req_addr == 12'h781) e = m_fromhost;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (core_tohost_wen) m_tohost = W'(core_tohost_wdata);
        else if (CLR_ON_READ && acc && !req_rw && req_addr == 12'h780) m_tohost = '0;
        if (acc && req_rw && req_addr == 12'h781) m_fromhost = req_data;
        else if (core_fromhost_clr) m_fromhost = '0;
        if (acc) m_valid = 1'b1;
        else if (resp_ready) m_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, W'(req_ready), W'(1'b1));
        check({tag, "_resp_valid"}, W'(resp_valid), W'(1'b0));
        check({tag, "_resp_data"}, resp_data, '0);
        check({tag, "_fromhost_rdata"}, W'(core_fromhost_rdata), '0);
        check({tag, "_tohost_pending"}, W'(tohost_pending), W'(1'b0));
    endtask

    initial begin
        // Reset state
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // Core writes tohost, host reads it twice
        core_tohost_wen = 1'b1; core_tohost_wdata = 32'h1;
        step();
        core_tohost_wen = 1'b0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780;
        step();
        step();
        req_valid = 1'b0;
        step();
        check("tohost_pending_after_reads", W'(tohost_pending), W'(!CLR_ON_READ));

        // Host writes fromhost, core sees low word, core clears, host reads back
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 12'h781; req_data = 64'hDEAD_BEEF_0000_0005;
        step();
        req_valid = 1'b0;
        step();
        check("fromhost_low_word", W'(core_fromhost_rdata), W'(32'h5));
        core_fromhost_clr = 1'b1;
        step();
        core_fromhost_clr = 1'b0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h781;
        step();
        // Host write and core clear in the same cycle: host wins
        req_rw = 1'b1; req_data = 64'h0123_4567_89AB_CDEF; core_fromhost_clr = 1'b1;
        step();
        core_fromhost_clr = 1'b0; req_rw = 1'b0;
        step();
        req_valid = 1'b0;
        step();

        // Backpressure: response held stable while resp_ready is low
        core_tohost_wen = 1'b1; core_tohost_wdata = 32'h77;
        step();
        core_tohost_wen = 1'b0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780;
        step();
        held = resp_data;
        resp_ready = 1'b0; req_addr = 12'h781;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_resp_data", resp_data, held);
        end
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();

        // Back-to-back reads with a core write in the middle
        n_resp = 0; cnt_2a = 0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780;
        for (int i = 0; i < 20; i++) begin
            core_tohost_wen   = (i == 10);
            core_tohost_wdata = 32'h2A;
            step();
        end
        core_tohost_wen = 1'b0; req_valid = 1'b0;
        step();
        check("burst_resp_count", W'(n_resp), W'(20));
        check("burst_2a_count", W'(cnt_2a), CLR_ON_READ ? W'(1) : W'(9));

        // Unmapped address read and write, then confirm registers
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h300;
        step();
        req_rw = 1'b1; req_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        req_rw = 1'b1; req_addr = 12'h780;
        step();
        req_rw = 1'b0;
        step();
        req_addr = 12'h781;
        step();
        req_valid = 1'b0;
        step();

        // Asynchronous reset while a response is pending
        core_tohost_wen = 1'b1; core_tohost_wdata = 32'h9;
        step();
        core_tohost_wen = 1'b0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h781;
        step();
        req_valid = 1'b0; resp_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        m_valid = 1'b0; m_tohost = '0; m_fromhost = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1; resp_ready = 1'b1;
        step();
        step();
        check("post_reset_resp_valid", W'(resp_valid), W'(1'b0));
        check("post_reset_queue_empty", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
